// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared types and helpers for the GS register-file write path
package gs_pkg;

  localparam int GS_NREG = 32;
  localparam int GS_XLEN = 32;

  typedef logic [4:0] gs_reg_idx_t;

  typedef struct packed {
    gs_reg_idx_t        rd;
    logic [GS_XLEN-1:0] data;
  } gs_wb_req_t;

  // One-hot register mask; x0 maps to an empty mask so it can never be marked busy.
  function automatic logic [GS_NREG-1:0] gs_reg_mask(input gs_reg_idx_t r);
    logic [GS_NREG-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gs_rr_arbiter.sv
// rtl/gs_rr_arbiter.sv - round-robin one-hot arbiter with internal priority pointer
module gs_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_d;

  // Scan from the pointer, wrapping, and take the first requester.
  always_comb begin
    int  idx;
    logic found;
    gnt_d = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
          ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  assign gnt_o = gnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gs_writeback_arbiter.sv
// rtl/gs_writeback_arbiter.sv - merges functional-unit results into the register-file write port
module gs_writeback_arbiter
  import gs_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  input  logic [4:0]            chk_rs1,
  input  logic [4:0]            chk_rs2,
  output logic                  hazard,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*5-1:0]    src_rd,
  input  logic [N_SRC*XLEN-1:0] src_data,
  output logic [N_SRC-1:0]      src_ready,
  output logic                  rd_wen,
  output logic [4:0]            rd_addr,
  output logic [XLEN-1:0]       rd_data,
  output logic [GS_NREG-1:0]    busy
);

  logic [N_SRC-1:0]   gnt;
  logic               gnt_any;
  gs_reg_idx_t        sel_rd;
  logic [XLEN-1:0]    sel_data;

  logic               rd_wen_q, rd_wen_d;
  gs_reg_idx_t        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]    rd_data_q, rd_data_d;
  logic [GS_NREG-1:0] busy_q, busy_d;

  // Grants are suppressed while reset is held so no result is consumed and lost.
  gs_rr_arbiter #(.N(N_SRC)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rst),
    .req_i (src_valid),
    .gnt_o (gnt)
  );

  assign src_ready = gnt;
  assign gnt_any   = |gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        sel_rd   = src_rd[i*5 +: 5];
        sel_data = src_data[i*XLEN +: XLEN];
      end
    end
  end

  // Set is applied after clear so an issue to the same rd at the retiring edge keeps it busy.
  always_comb begin
    rd_wen_d  = gnt_any && (sel_rd != '0);
    rd_addr_d = gnt_any ? sel_rd : rd_addr_q;
    rd_data_d = gnt_any ? sel_data : rd_data_q;
    busy_d    = busy_q;
    if (gnt_any)   busy_d = busy_d & ~gs_reg_mask(sel_rd);
    if (iss_valid) busy_d = busy_d | gs_reg_mask(iss_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
    end else begin
      rd_wen_q  <= rd_wen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_wen  = rd_wen_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;

  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[iss_rd];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src_chk
    a_rd_reserved: assert property (@(posedge clk) disable iff (!rst)
      (src_valid[g] && (src_rd[g*5 +: 5] != 5'd0)) |-> busy_q[src_rd[g*5 +: 5]]);
  end

endmodule

// File: tb/tb_gs_writeback_arbiter.sv
// tb/tb_gs_writeback_arbiter.sv - scoreboard bench for gs_writeback_arbiter
module tb_gs_writeback_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic [4:0]    iss_rd, chk_rs1, chk_rs2;
  logic          hazard;
  logic [N-1:0]  src_valid;
  logic [N*5-1:0]  src_rd;
  logic [N*XL-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic          rd_wen;
  logic [4:0]    rd_addr;
  logic [XL-1:0] rd_data;
  logic [31:0]   busy;

  gs_writeback_arbiter #(.N_SRC(N), .XLEN(XL)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .hazard    (hazard),
    .src_valid (src_valid),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_ready (src_ready),
    .rd_wen    (rd_wen),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]        = v;
    src_rd[i*5 +: 5]    = rd;
    src_data[i*XL +: XL] = d;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && rd_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 64'(rd_addr), 64'(e.rd));
        chk("wb_data", 64'(rd_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst       = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    chk_rs1   = '0;
    chk_rs2   = '0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'd0, 32'h0);

    // Reset with all sources requesting
    tick();
    tick();
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_wen", 64'(rd_wen), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    #1;
    chk("first_grant", 64'(src_ready), 64'b001);
    tick();
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_after_rst_wen", 64'(rd_wen), 64'd0);

    // Single write: pointer now 1
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    tick();
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    chk("busy5_set", 64'(busy), 64'h20);
    set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 64'(src_ready), 64'b010);
    push_exp(5'd5, 32'hDEADBEEF);
    tick();
    set_src(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("single_wen", 64'(rd_wen), 64'd1);
    chk("busy5_clr", 64'(busy), 64'd0);

    // Set/clear collision on x7: pointer now 2
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    tick();
    chk("busy7_set", 64'(busy), 64'h80);
    set_src(2, 1'b1, 5'd7, 32'h00000777);
    #1;
    chk("coll_ready", 64'(src_ready), 64'b100);
    push_exp(5'd7, 32'h00000777);
    tick();
    set_src(2, 1'b0, 5'd0, 32'h0);
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    #1;
    chk("coll_busy7", 64'(busy), 64'h80);
    chk("coll_wen", 64'(rd_wen), 64'd1);

    // Round-robin: reserve x10..x15, pointer now 0
    for (int r = 10; r <= 15; r++) begin
      iss_valid = 1'b1;
      iss_rd    = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    chk("rr_busy", 64'(busy), 64'h0000_FC80);
    set_src(0, 1'b1, 5'd10, 32'hA000_000A);
    set_src(1, 1'b1, 5'd11, 32'hA000_000B);
    set_src(2, 1'b1, 5'd12, 32'hA000_000C);
    for (int c = 0; c < 6; c++) begin
      int g;
      logic [4:0] r;
      g = c % 3;
      r = 5'(10 + c);
      #1;
      chk($sformatf("rr_grant%0d", c), 64'(src_ready), 64'(1 << g));
      push_exp(r, 32'hA000_0000 + 32'(r));
      tick();
      if (c < 3) set_src(g, 1'b1, 5'(13 + c), 32'hA000_0000 + 32'(13 + c));
      else       set_src(g, 1'b0, 5'd0, 32'h0);
      chk($sformatf("rr_wen%0d", c), 64'(rd_wen), 64'd1);
    end
    #1;
    chk("rr_busy_after", 64'(busy), 64'h80);

    // x0 write: pointer back at 0
    set_src(0, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("x0_ready", 64'(src_ready), 64'b001);
    tick();
    set_src(0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_wen", 64'(rd_wen), 64'd0);
    chk("x0_busy", 64'(busy), 64'h80);

    // Hazard compare against busy x3
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    tick();
    iss_valid = 1'b0;
    chk_rs1 = 5'd3; chk_rs2 = 5'd4; iss_rd = 5'd4;
    #1;
    chk("haz_rs1", 64'(hazard), 64'd1);
    chk_rs1 = 5'd4; chk_rs2 = 5'd3; iss_rd = 5'd4;
    #1;
    chk("haz_rs2", 64'(hazard), 64'd1);
    chk_rs1 = 5'd4; chk_rs2 = 5'd4; iss_rd = 5'd3;
    #1;
    chk("haz_rd", 64'(hazard), 64'd1);
    chk_rs1 = 5'd4; chk_rs2 = 5'd4; iss_rd = 5'd4;
    #1;
    chk("haz_none", 64'(hazard), 64'd0);

    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
